// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port synchronous memory (1-cycle read
// latency) between instruction fetch and the data stage. Grants are
// combinational; data has priority over fetch. The owner of the in-flight read
// is registered so the returned word can be steered to the right requester.
// Optional fetch anti-starvation guard: define UNIFIED_ARB_FAIRNESS_EN.
module unified_mem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [31:0]   if_rdata_o,
   input  logic          d_req_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic          d_read_i,
   input  logic [3:0]    d_write_byte_i,
   input  logic [31:0]   d_wdata_i,
   output logic          d_gnt_o,
   output logic          d_rvalid_o,
   output logic [31:0]   d_rdata_o,
   output logic [AW-1:0] mem_addr_o,
   output logic          mem_read_o,
   output logic [3:0]    mem_write_byte_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t      owner_p1;
   owner_t      owner_next;
   logic        force_if;
   logic        d_gnt;
   logic        if_gnt;
   logic [31:0] if_hold_p1;
   logic [31:0] d_hold_p1;

`ifdef UNIFIED_ARB_FAIRNESS_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt_p1;

   // Fetch wins the cycle once it has been denied STARVE_MAX times in a row.
   assign force_if = if_req_i && (starve_cnt_p1 == STARVE_LIM);

   // Count consecutive cycles in which a waiting fetch loses to data.
   always_ff @(posedge clk) begin
      if (!reset_n)
         starve_cnt_p1 <= 4'd0;
      else if (!if_req_i || if_gnt)
         starve_cnt_p1 <= 4'd0;
      else if (d_req_i)
         starve_cnt_p1 <= starve_cnt_p1 + 4'd1;
   end
`else
   logic unused_starve_cfg;

   assign force_if          = 1'b0;
   assign unused_starve_cfg = ^4'(STARVE_MAX);
`endif

   // Fixed data-over-fetch priority, overridden only by the starvation guard.
   always_comb begin
      d_gnt  = reset_n && d_req_i && !force_if;
      if_gnt = reset_n && if_req_i && (!d_req_i || force_if);
   end

   assign d_gnt_o  = d_gnt;
   assign if_gnt_o = if_gnt;

   // Steer the granted requester onto the memory port; an idle port still shows the fetch address.
   always_comb begin
      mem_addr_o       = if_addr_i;
      mem_read_o       = 1'b0;
      mem_write_byte_o = 4'd0;
      mem_wdata_o      = 32'd0;
      if (d_gnt) begin
         mem_addr_o       = d_addr_i;
         mem_read_o       = d_read_i;
         mem_write_byte_o = d_read_i ? 4'd0 : d_write_byte_i;
         mem_wdata_o      = d_wdata_i;
      end else if (if_gnt) begin
         mem_read_o = 1'b1;
      end
   end

   // Owner state register: who the word coming back next cycle belongs to.
   always_ff @(posedge clk) begin
      if (!reset_n)
         owner_p1 <= OWN_NONE;
      else
         owner_p1 <= owner_next;
   end

   // Next owner: only granted reads leave a response in flight; stores do not.
   always_comb begin
      owner_next = OWN_NONE;
      if (d_gnt && d_read_i)
         owner_next = OWN_D;
      else if (if_gnt)
         owner_next = OWN_IF;
   end

   // Responses are combinational from the owner; reset drops an in-flight word.
   assign if_rvalid_o = reset_n && (owner_p1 == OWN_IF);
   assign d_rvalid_o  = reset_n && (owner_p1 == OWN_D);
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_hold_p1;
   assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : d_hold_p1;

   // Holding registers keep the last word delivered to each requester.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         if_hold_p1 <= 32'd0;
         d_hold_p1  <= 32'd0;
      end else begin
         if (if_rvalid_o)
            if_hold_p1 <= mem_rdata_i;
         if (d_rvalid_o)
            d_hold_p1 <= mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a memory model answers reads one cycle late;
// expected read words are queued at grant time and compared on return.
// Honours UNIFIED_ARB_FAIRNESS_EN in its reference grant model.
module tb_unified_mem_arbiter;

   localparam int unsigned AW         = 32;
   localparam int unsigned STARVE_MAX = 4;
`ifdef UNIFIED_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic          clk;
   logic          reset_n;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o;
   logic          if_rvalid_o;
   logic [31:0]   if_rdata_o;
   logic          d_req_i;
   logic [AW-1:0] d_addr_i;
   logic          d_read_i;
   logic [3:0]    d_write_byte_i;
   logic [31:0]   d_wdata_i;
   logic          d_gnt_o;
   logic          d_rvalid_o;
   logic [31:0]   d_rdata_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_read_o;
   logic [3:0]    mem_write_byte_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i;

   unified_mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .if_req_i         (if_req_i),
      .if_addr_i        (if_addr_i),
      .if_gnt_o         (if_gnt_o),
      .if_rvalid_o      (if_rvalid_o),
      .if_rdata_o       (if_rdata_o),
      .d_req_i          (d_req_i),
      .d_addr_i         (d_addr_i),
      .d_read_i         (d_read_i),
      .d_write_byte_i   (d_write_byte_i),
      .d_wdata_i        (d_wdata_i),
      .d_gnt_o          (d_gnt_o),
      .d_rvalid_o       (d_rvalid_o),
      .d_rdata_o        (d_rdata_o),
      .mem_addr_o       (mem_addr_o),
      .mem_read_o       (mem_read_o),
      .mem_write_byte_o (mem_write_byte_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_rdata_i      (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem    [0:1023];
   logic [31:0] shadow [0:1023];
   logic [31:0] if_q [$];
   logic [31:0] d_q  [$];
   logic [31:0] last_if;
   logic [31:0] last_d;
   int          m_cnt;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] apply_lanes(input logic [31:0] old, input logic [31:0] w,
                                               input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = w[8*b +: 8];
      return r;
   endfunction

   // Single-port memory: one-cycle read latency, byte-lane writes.
   always @(posedge clk) begin
      if (mem_write_byte_o != 4'd0)
         mem[mem_addr_o[9:0]] <= apply_lanes(mem[mem_addr_o[9:0]], mem_wdata_o, mem_write_byte_o);
      if (mem_read_o)
         mem_rdata_i <= mem[mem_addr_o[9:0]];
   end

   // One cycle: drive inputs, check grants/memory drive/responses, update the model.
   task automatic step(input logic rn, input logic ir, input logic [AW-1:0] ia,
                       input logic dq, input logic [AW-1:0] da, input logic drd,
                       input logic [3:0] dwb, input logic [31:0] dwd);
      logic          fi, eg_d, eg_i, er;
      logic [AW-1:0] ea;
      logic [3:0]    ewb;
      logic [31:0]   ewd, e;
      @(negedge clk);
      reset_n        = rn;
      if_req_i       = ir;
      if_addr_i      = ia;
      d_req_i        = dq;
      d_addr_i       = da;
      d_read_i       = drd;
      d_write_byte_i = dwb;
      d_wdata_i      = dwd;
      #1;
      fi   = FAIR && ir && (m_cnt == STARVE_MAX);
      eg_d = rn && dq && !fi;
      eg_i = rn && ir && (!dq || fi);
      check_val("d_gnt", d_gnt_o, eg_d);
      check_val("if_gnt", if_gnt_o, eg_i);
      ea = ia; er = 1'b0; ewb = 4'd0; ewd = 32'd0;
      if (eg_d) begin
         ea = da; er = drd; ewb = drd ? 4'd0 : dwb; ewd = dwd;
      end else if (eg_i) begin
         er = 1'b1;
      end
      check_val("mem_addr", mem_addr_o, ea);
      check_val("mem_read", mem_read_o, er);
      check_val("mem_wbe", mem_write_byte_o, ewb);
      check_val("mem_wdata", mem_wdata_o, ewd);
      if (!rn) begin
         check_val("if_rvalid_rst", if_rvalid_o, 1'b0);
         check_val("d_rvalid_rst", d_rvalid_o, 1'b0);
         if_q.delete();
         d_q.delete();
         last_if = 32'd0;
         last_d  = 32'd0;
      end else begin
         if (if_q.size() != 0) begin
            e = if_q.pop_front();
            check_val("if_rvalid", if_rvalid_o, 1'b1);
            check_val("if_rdata", if_rdata_o, e);
            last_if = e;
         end else begin
            check_val("if_rvalid_idle", if_rvalid_o, 1'b0);
            check_val("if_rdata_hold", if_rdata_o, last_if);
         end
         if (d_q.size() != 0) begin
            e = d_q.pop_front();
            check_val("d_rvalid", d_rvalid_o, 1'b1);
            check_val("d_rdata", d_rdata_o, e);
            last_d = e;
         end else begin
            check_val("d_rvalid_idle", d_rvalid_o, 1'b0);
            check_val("d_rdata_hold", d_rdata_o, last_d);
         end
      end
      if (eg_d && drd) d_q.push_back(shadow[da[9:0]]);
      if (eg_d && !drd) shadow[da[9:0]] = apply_lanes(shadow[da[9:0]], dwd, dwb);
      if (eg_i) if_q.push_back(shadow[ia[9:0]]);
      if (!rn || !ir || eg_i) m_cnt = 0;
      else if (dq) m_cnt++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]    = 32'hC0DE_0000 + 32'(i) * 32'd7 + 32'd1;
         shadow[i] = 32'hC0DE_0000 + 32'(i) * 32'd7 + 32'd1;
      end
      mem[10'h100] = 32'hDEADBEEF; shadow[10'h100] = 32'hDEADBEEF;
      mem[10'h200] = 32'h1234_5678; shadow[10'h200] = 32'h1234_5678;
      mem_rdata_i = 32'd0;
      last_if = 32'd0; last_d = 32'd0; m_cnt = 0;
      reset_n = 1'b0; if_req_i = 1'b0; if_addr_i = '0; d_req_i = 1'b0; d_addr_i = '0;
      d_read_i = 1'b0; d_write_byte_i = 4'h0; d_wdata_i = 32'h0;

      // Reset with requests pending: no grants, no responses.
      step(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 4'h0, 32'h0);
      step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      idle(1);

      // Fetch-only read returning 0xDEADBEEF, then held.
      step(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      idle(3);
      check_val("t1_if_hold", if_rdata_o, 32'hDEADBEEF);

      // Conflict: data load wins, fetch granted next cycle, back-to-back returns.
      step(1'b1, 1'b1, 32'h0, 1'b1, 32'h200, 1'b1, 4'h0, 32'h0);
      step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      idle(2);

      // Byte store with fetch pending, then read back the merged word.
      step(1'b1, 1'b1, 32'h4, 1'b1, 32'h202, 1'b0, 4'b0100, 32'h00AB0000);
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h202, 1'b1, 4'h0, 32'h0);
      idle(1);
      check_val("t3_merge", d_rdata_o, apply_lanes(32'hC0DE_0000 + 32'h202 * 32'd7 + 32'd1,
                                                   32'h00AB0000, 4'b0100));

      // Empty data request: granted, no memory effect.
      step(1'b1, 1'b1, 32'h8, 1'b1, 32'h300, 1'b0, 4'h0, 32'h55);
      idle(1);

      // Sustained contention for six cycles.
      for (int k = 0; k < 6; k++)
         step(1'b1, 1'b1, 32'h10 + 32'(k), 1'b1, 32'h20 + 32'(k), 1'b1, 4'h0, 32'h0);
      idle(2);

      // Reset during an in-flight load.
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 4'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      idle(2);
      check_val("t5_d_rdata0", d_rdata_o, 32'h0);
      check_val("t5_if_rdata0", if_rdata_o, 32'h0);

      // Illegal load with lanes set: load wins, write suppressed.
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 4'b1111, 32'hFFFF_FFFF);
      idle(1);
      check_val("t6_no_write", d_rdata_o, 32'hDEADBEEF);

      // Randomised traffic with occasional resets.
      for (int k = 0; k < 400; k++)
         step(($urandom_range(0, 40) != 0), 1'($urandom_range(0, 3) != 0), AW'($urandom()),
              1'($urandom_range(0, 2) != 0), AW'($urandom()), 1'($urandom()),
              4'($urandom()), $urandom());
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
